// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter and its lane-merge helper.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

  localparam logic [3:0] BE_FULL  = 4'hF;
  localparam logic [3:0] BE_NONE  = 4'h0;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: enabled lanes come from the store data,
// the rest from the word currently held in memory.
module dmem_byte_merge
  import dmem_arb_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [31:0] old,
  output logic [31:0] merged
);

  // per-lane select between new and old byte
  always_comb begin
    merged = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the core LSU (req0) and debug/DMA (req1) for the
// single-port word-write dmem; sub-word stores become read-modify-write.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AddrW = 32,
  parameter int DataW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_we,
  input  logic [3:0]       req0_be,
  input  logic [AddrW-1:0] req0_addr,
  input  logic [DataW-1:0] req0_wdata,
  output logic             req0_rvalid,
  output logic [DataW-1:0] req0_rdata,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_we,
  input  logic [3:0]       req1_be,
  input  logic [AddrW-1:0] req1_addr,
  input  logic [DataW-1:0] req1_wdata,
  output logic             req1_rvalid,
  output logic [DataW-1:0] req1_rdata,
  output logic             mem_r_w,
  output logic [AddrW-1:0] mem_addr,
  output logic [DataW-1:0] mem_data,
  input  logic [DataW-1:0] mem_out
);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [AddrW-1:0] lat_addr;
  logic [DataW-1:0] lat_wdata;
  logic [3:0]       lat_be;
  logic             lat_we;
  logic             lat_id;
  logic             last_grant;
  logic [DataW-1:0] merge_word;
  logic [DataW-1:0] resp_word;
  logic [DataW-1:0] merged;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             sel_we;
  logic [3:0]       sel_be;
  logic [AddrW-1:0] sel_addr;
  logic [DataW-1:0] sel_wdata;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = REQ_DBG;
    end else begin
      grant_id = REQ_CORE;
    end
  end

  assign accept = (state == ST_IDLE) & grant_valid & ~reset;

  // request field mux for the grantee
  always_comb begin
    if (grant_id == REQ_DBG) begin
      sel_we    = req1_we;
      sel_be    = req1_be;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end else begin
      sel_we    = req0_we;
      sel_be    = req0_be;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
    end
  end

  dmem_byte_merge u_merge (
    .be     (lat_be),
    .wdata  (lat_wdata),
    .old    (mem_out),
    .merged (merged)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (!accept) begin
          state_next = ST_IDLE;
        end else if (!sel_we) begin
          state_next = ST_RD;
        end else if ((sel_be == BE_FULL) || (sel_be == BE_NONE)) begin
          state_next = ST_WR;
        end else begin
          state_next = ST_RMW_RD;
        end
      end
      ST_RD:     state_next = ST_RESP;
      ST_RMW_RD: state_next = ST_WR;
      ST_WR:     state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; the write strobe is gated by reset so an interrupted store never lands
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_rvalid = 1'b0;
    req1_rvalid = 1'b0;
    mem_r_w     = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = accept & (grant_id == REQ_CORE);
        req1_ready = accept & (grant_id == REQ_DBG);
      end
      ST_WR: begin
        mem_r_w = (lat_be != BE_NONE) & ~reset;
      end
      ST_RESP: begin
        req0_rvalid = (lat_id == REQ_CORE);
        req1_rvalid = (lat_id == REQ_DBG);
      end
      default: begin
        mem_r_w = 1'b0;
      end
    endcase
    req0_rdata = req0_rvalid ? resp_word : {DataW{1'b0}};
    req1_rdata = req1_rvalid ? resp_word : {DataW{1'b0}};
  end

  assign mem_addr = lat_addr;
  assign mem_data = (lat_be == BE_FULL) ? lat_wdata : merge_word;

  // Request latch, response capture and RMW merge register
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr   <= {AddrW{1'b0}};
      lat_wdata  <= {DataW{1'b0}};
      lat_be     <= 4'h0;
      lat_we     <= 1'b0;
      lat_id     <= REQ_CORE;
      last_grant <= REQ_DBG;
      merge_word <= {DataW{1'b0}};
      resp_word  <= {DataW{1'b0}};
    end else if (accept) begin
      lat_addr   <= sel_addr;
      lat_wdata  <= sel_wdata;
      lat_be     <= sel_be;
      lat_we     <= sel_we;
      lat_id     <= grant_id;
      last_grant <= grant_id;
      resp_word  <= {DataW{1'b0}};
    end else if ((state == ST_RD) && !lat_we) begin
      resp_word  <= mem_out;
    end else if (state == ST_RMW_RD) begin
      merge_word <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word-write dmem model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, req0_rvalid;
  logic [3:0]  req0_be;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_rvalid;
  logic [3:0]  req1_be;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_r_w;
  logic [31:0] mem_addr, mem_data, mem_out;

  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = 32'h0;
  logic [31:0] bd_data = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_out = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_r_w) mem[mem_addr[9:2]] <= mem_data;
    else if (bd_we) mem[bd_addr[9:2]] <= bd_data;
  end

  dmem_arbiter #(.AddrW(32), .DataW(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_be(req0_be), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_be(req1_be), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_be = be; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_we = we; req1_be = be; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one request and follow it to its rvalid; latencies counted from the accept cycle.
  task automatic access(input int port, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output int writes,
                        output int wr_at, output int wrong, output int waits);
    bit got;
    rdata = 32'h0; lat = -1; writes = 0; wr_at = -1; wrong = 0; waits = 0; got = 1'b0;
    set_req(port, 1'b1, we, be, addr, wdata);
    for (int w = 0; w < 10 && !got; w++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
      else begin waits++; @(negedge clk); end
    end
    chk("accept", 32'(got), 32'd1);
    if (got) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) set_req(port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        if (mem_r_w) begin writes++; wr_at = k; end
        if ((port == 0) ? req1_rvalid : req0_rvalid) wrong = 1;
        if ((port == 0) ? req0_rvalid : req1_rvalid) begin
          lat = k;
          rdata = (port == 0) ? req0_rdata : req1_rdata;
          break;
        end
      end
    end else begin
      set_req(port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, writes, wr_at, wrong, waits;
    int n_grant, n_resp;
    logic q_id [$];
    logic pid;

    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1 chk("ready_forced_low_in_reset", 32'(req0_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_flags", 32'({req0_ready, req1_ready, req0_rvalid, req1_rvalid, mem_r_w}), 32'd0);
    chk("reset_rdata0", req0_rdata, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_data", mem_data, 32'h0);

    // load from core
    poke(32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat, writes, wr_at, wrong, waits);
    chk("load_ready_c0", 32'(waits), 32'd0);
    chk("load_rdata", rd, 32'hDEADBEEF);
    chk("load_latency", 32'(lat), 32'd2);
    chk("load_no_write", 32'(writes), 32'd0);

    // full-word store from debug, read back
    access(1, 1'b1, 4'hF, 32'h20, 32'h12345678, rd, lat, writes, wr_at, wrong, waits);
    chk("fstore_writes", 32'(writes), 32'd1);
    chk("fstore_write_cycle", 32'(wr_at), 32'd1);
    chk("fstore_latency", 32'(lat), 32'd2);
    chk("fstore_rdata_zero", rd, 32'h0);
    chk("fstore_port", 32'(wrong), 32'd0);
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat, writes, wr_at, wrong, waits);
    chk("fstore_readback", rd, 32'h12345678);

    // partial store -> read-modify-write
    poke(32'h50, 32'hAABBCCDD);
    access(1, 1'b1, 4'b0101, 32'h50, 32'h11223344, rd, lat, writes, wr_at, wrong, waits);
    chk("pstore_latency", 32'(lat), 32'd3);
    chk("pstore_write_cycle", 32'(wr_at), 32'd2);
    chk("pstore_writes", 32'(writes), 32'd1);
    access(0, 1'b0, 4'h0, 32'h50, 32'h0, rd, lat, writes, wr_at, wrong, waits);
    chk("pstore_readback", rd, 32'hAA22CC44);

    // be == 0 store is an acknowledged no-op
    poke(32'h40, 32'h55AA55AA);
    access(0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, rd, lat, writes, wr_at, wrong, waits);
    chk("be0_writes", 32'(writes), 32'd0);
    chk("be0_latency", 32'(lat), 32'd2);
    chk("be0_mem_unchanged", mem[8'h10], 32'h55AA55AA);

    // debug access so core wins the next tie
    access(1, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat, writes, wr_at, wrong, waits);
    chk("dbg_load_rdata", rd, 32'h12345678);

    // sustained contention: grants must alternate 0,1,0,1,0,1
    set_req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'h0, 32'h50, 32'h0);
    n_grant = 0; n_resp = 0;
    for (int c = 0; c < 80 && n_resp < 6; c++) begin
      @(negedge clk);
      if (n_grant == 6) begin
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      #1;
      if (req0_rvalid || req1_rvalid) begin
        pid = (q_id.size() > 0) ? q_id.pop_front() : 1'b0;
        chk("arb_resp_port", 32'({req0_rvalid, req1_rvalid}), (pid == 1'b0) ? 32'd2 : 32'd1);
        chk("arb_resp_data", pid ? req1_rdata : req0_rdata,
            (pid == 1'b0) ? 32'hDEADBEEF : 32'hAA22CC44);
        n_resp++;
      end
      if (n_grant < 6 && (req0_ready || req1_ready)) begin
        chk("arb_grant_order", 32'({req0_ready, req1_ready}), (n_grant % 2 == 0) ? 32'd2 : 32'd1);
        q_id.push_back(req1_ready);
        n_grant++;
      end
    end
    chk("arb_resp_count", 32'(n_resp), 32'd6);

    // reset in the middle of a store's WR cycle
    poke(32'h30, 32'h0);
    set_req(0, 1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
    #1 chk("rst_store_accept", 32'(req0_ready), 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #1 chk("rst_in_wr_no_write", 32'(mem_r_w), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wr_flags", 32'({req0_ready, req1_ready, req0_rvalid, req1_rvalid, mem_r_w}), 32'd0);
    chk("rst_wr_rdata1", req1_rdata, 32'h0);
    chk("rst_wr_mem_addr", mem_addr, 32'h0);
    chk("rst_wr_mem_data", mem_data, 32'h0);
    chk("rst_wr_mem_intact", mem[8'h0C], 32'h0);
    access(0, 1'b0, 4'h0, 32'h30, 32'h0, rd, lat, writes, wr_at, wrong, waits);
    chk("rst_wr_readback", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
